// File: rtl/pong_game_ctrl_if.sv
// Ball-side bus of the pong game controller: ball control outputs, collision flag, lives and score.
interface pong_game_ctrl_if;
    logic [3:0]  game_over_flag;
    logic [3:0]  game_state;
    logic [31:0] ball_time_const;
    logic [1:0]  lives;
    logic [15:0] score;

    modport master (
        input  game_over_flag,
        output game_state,
        output ball_time_const,
        output lives,
        output score
    );

    modport slave (
        output game_over_flag,
        input  game_state,
        input  ball_time_const,
        input  lives,
        input  score
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start key, serve countdown, lives, survival score.
// Optional speed ramp during PLAY is built when GAME_CTRL_SPEED_RAMP_EN is defined.
module pong_game_ctrl #(
    parameter int CLKS_PER_MS     = 50000,
    parameter int SERVE_MS        = 1500,
    parameter int HIT_MS          = 500,
    parameter int RAMP_MS         = 5000,
    parameter int TIME_CONST_INIT = 1000,
    parameter int TIME_CONST_MIN  = 250,
    parameter int TIME_CONST_STEP = 50,
    parameter int LIVES_INIT      = 3
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            key_start,
    pong_game_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        PLAY  = 4'd0,
        IDLE  = 4'd1,
        SERVE = 4'd2,
        HIT   = 4'd3,
        OVER  = 4'd4
    } state_t;

    if (LIVES_INIT < 1 || LIVES_INIT > 3 || CLKS_PER_MS < 1 || SERVE_MS < 1 || HIT_MS < 1 ||
        RAMP_MS < 1 || TIME_CONST_STEP < 0 || TIME_CONST_MIN > TIME_CONST_INIT) begin : g_bad_params
        $error("pong_game_ctrl: inconsistent parameters");
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state, state_nxt;
    logic        key_p0, key_p1, key_p2;
    logic        start_pulse;
    logic        game_start;
    logic        flag_hit;
    logic        ms_tick;
    logic        sec_evt;
    logic [31:0] presc;
    logic [31:0] timer;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        unused_flag_bits;

    assign unused_flag_bits = &{1'b0, bus.game_over_flag[3:1]};

    // Key is active-low; a falling edge after the two-flop synchronizer is a press.
    assign start_pulse = key_p2 & ~key_p1;
    assign ms_tick     = (presc == 32'(CLKS_PER_MS - 1));
    assign flag_hit    = (state == PLAY) && bus.game_over_flag[0];
    assign sec_evt     = (state == PLAY) && ms_tick && !bus.game_over_flag[0] && (timer == 32'd999);

    always_comb begin
        state_nxt  = state;
        game_start = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start_pulse) begin
                    state_nxt  = SERVE;
                    game_start = 1'b1;
                end
            end
            SERVE: if (ms_tick && timer == 32'(SERVE_MS - 1)) state_nxt = PLAY;
            PLAY:  if (bus.game_over_flag[0]) state_nxt = HIT;
            HIT:   if (ms_tick && timer == 32'(HIT_MS - 1)) state_nxt = (lives == 2'd0) ? OVER : SERVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            key_p2 <= 1'b1;
            presc  <= '0;
            timer  <= '0;
            lives  <= '0;
            score  <= '0;
        end else begin
            key_p0 <= key_start;
            key_p1 <= key_p0;
            key_p2 <= key_p1;
            state  <= state_nxt;
            // Timebase restarts on every transition so each state lasts exactly N ms.
            if (state_nxt != state) begin
                presc <= '0;
                timer <= '0;
            end else begin
                presc <= ms_tick ? '0 : presc + 32'd1;
                if (ms_tick)
                    timer <= (state == PLAY && timer == 32'd999) ? '0 : timer + 32'd1;
            end
            if (game_start) begin
                lives <= 2'(LIVES_INIT);
                score <= '0;
            end else if (flag_hit) begin
                lives <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            end else if (sec_evt) begin
                score <= sat_inc(score);
            end
        end
    end

`ifdef GAME_CTRL_SPEED_RAMP_EN
    function automatic logic [31:0] ramp_step(input logic [31:0] tc);
        return (tc < 32'(TIME_CONST_MIN + TIME_CONST_STEP)) ? 32'(TIME_CONST_MIN)
                                                          : tc - 32'(TIME_CONST_STEP);
    endfunction

    logic [31:0] ramp_cnt;
    logic [31:0] time_const;

    // Ramp counter only advances on PLAY ticks without a collision; it survives SERVE/HIT.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            ramp_cnt   <= '0;
            time_const <= 32'(TIME_CONST_INIT);
        end else if (game_start) begin
            ramp_cnt   <= '0;
            time_const <= 32'(TIME_CONST_INIT);
        end else if (state == PLAY && ms_tick && !bus.game_over_flag[0]) begin
            if (ramp_cnt == 32'(RAMP_MS - 1)) begin
                ramp_cnt   <= '0;
                time_const <= ramp_step(time_const);
            end else begin
                ramp_cnt <= ramp_cnt + 32'd1;
            end
        end
    end

    assign bus.ball_time_const = time_const;
`else
    assign bus.ball_time_const = 32'(TIME_CONST_INIT);
`endif

    assign bus.game_state = state;
    assign bus.lives      = lives;
    assign bus.score      = score;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a small timebase (4 clocks per ms).
module tb_pong_game_ctrl;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    logic key_start = 1'b1;
    int   checks   = 0;
    int   failures = 0;

`ifdef GAME_CTRL_SPEED_RAMP_EN
    localparam logic [31:0] EXP_TC_5MS  = 32'd85;
    localparam logic [31:0] EXP_TC_10MS = 32'd80;
`else
    localparam logic [31:0] EXP_TC_5MS  = 32'd100;
    localparam logic [31:0] EXP_TC_10MS = 32'd100;
`endif

    pong_game_ctrl_if bus();

    pong_game_ctrl #(
        .CLKS_PER_MS(4), .SERVE_MS(3), .HIT_MS(2), .RAMP_MS(5),
        .TIME_CONST_INIT(100), .TIME_CONST_MIN(80), .TIME_CONST_STEP(15), .LIVES_INIT(2)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_start(key_start),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset;
        bus.game_over_flag = 4'd0;
        key_start = 1'b1;
        reset = 1'b0;
        cyc(3);
        checks++; if (bus.game_state !== 4'd1) begin failures++; $display("FAIL reset_state got=%0d exp=1", bus.game_state); end
        checks++; if (bus.lives !== 2'd0) begin failures++; $display("FAIL reset_lives got=%0d exp=0", bus.lives); end
        checks++; if (bus.score !== 16'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
        checks++; if (bus.ball_time_const !== 32'd100) begin failures++; $display("FAIL reset_tc got=%0d exp=100", bus.ball_time_const); end
        reset = 1'b1;
        cyc(2);
        checks++; if (bus.game_state !== 4'd1) begin failures++; $display("FAIL idle_hold got=%0d exp=1", bus.game_state); end
    endtask

    task automatic test_start;
        key_start = 1'b0;
        cyc(2);
        checks++; if (bus.game_state !== 4'd1) begin failures++; $display("FAIL start_early got=%0d exp=1", bus.game_state); end
        cyc(1);
        checks++; if (bus.game_state !== 4'd2) begin failures++; $display("FAIL start_serve got=%0d exp=2", bus.game_state); end
        checks++; if (bus.lives !== 2'd2) begin failures++; $display("FAIL start_lives got=%0d exp=2", bus.lives); end
        checks++; if (bus.score !== 16'd0) begin failures++; $display("FAIL start_score got=%0d exp=0", bus.score); end
        cyc(11);
        checks++; if (bus.game_state !== 4'd2) begin failures++; $display("FAIL serve_len_early got=%0d exp=2", bus.game_state); end
        cyc(1);
        checks++; if (bus.game_state !== 4'd0) begin failures++; $display("FAIL serve_to_play got=%0d exp=0", bus.game_state); end
        cyc(6);
        key_start = 1'b1;
    endtask

    // Entered 6 cycles after PLAY entry.
    task automatic test_play_score_ramp;
        cyc(13);
        checks++; if (bus.ball_time_const !== 32'd100) begin failures++; $display("FAIL ramp_before got=%0d exp=100", bus.ball_time_const); end
        cyc(1);
        checks++; if (bus.ball_time_const !== EXP_TC_5MS) begin failures++; $display("FAIL ramp_5ms got=%0d exp=%0d", bus.ball_time_const, EXP_TC_5MS); end
        cyc(20);
        checks++; if (bus.ball_time_const !== EXP_TC_10MS) begin failures++; $display("FAIL ramp_10ms got=%0d exp=%0d", bus.ball_time_const, EXP_TC_10MS); end
        cyc(20);
        checks++; if (bus.ball_time_const !== EXP_TC_10MS) begin failures++; $display("FAIL ramp_15ms got=%0d exp=%0d", bus.ball_time_const, EXP_TC_10MS); end
        cyc(3939);
        checks++; if (bus.score !== 16'd0) begin failures++; $display("FAIL score_early got=%0d exp=0", bus.score); end
        cyc(1);
        checks++; if (bus.score !== 16'd1) begin failures++; $display("FAIL score_1s got=%0d exp=1", bus.score); end
        checks++; if (bus.game_state !== 4'd0) begin failures++; $display("FAIL still_play got=%0d exp=0", bus.game_state); end
    endtask

    task automatic test_hit;
        bus.game_over_flag = 4'b0001;
        cyc(1);
        bus.game_over_flag = 4'd0;
        checks++; if (bus.game_state !== 4'd3) begin failures++; $display("FAIL hit_state got=%0d exp=3", bus.game_state); end
        checks++; if (bus.lives !== 2'd1) begin failures++; $display("FAIL hit_lives got=%0d exp=1", bus.lives); end
        checks++; if (bus.ball_time_const !== EXP_TC_10MS) begin failures++; $display("FAIL hit_tc got=%0d exp=%0d", bus.ball_time_const, EXP_TC_10MS); end
        cyc(7);
        checks++; if (bus.game_state !== 4'd3) begin failures++; $display("FAIL hit_len_early got=%0d exp=3", bus.game_state); end
        cyc(1);
        checks++; if (bus.game_state !== 4'd2) begin failures++; $display("FAIL hit_to_serve got=%0d exp=2", bus.game_state); end
        checks++; if (bus.score !== 16'd1) begin failures++; $display("FAIL hit_score_kept got=%0d exp=1", bus.score); end
    endtask

    task automatic test_over_restart;
        cyc(12);
        checks++; if (bus.game_state !== 4'd0) begin failures++; $display("FAIL replay got=%0d exp=0", bus.game_state); end
        key_start = 1'b0;
        bus.game_over_flag = 4'b1111;
        cyc(1);
        bus.game_over_flag = 4'd0;
        checks++; if (bus.lives !== 2'd0) begin failures++; $display("FAIL hit2_lives got=%0d exp=0", bus.lives); end
        cyc(8);
        checks++; if (bus.game_state !== 4'd4) begin failures++; $display("FAIL over_state got=%0d exp=4", bus.game_state); end
        cyc(10);
        checks++; if (bus.game_state !== 4'd4) begin failures++; $display("FAIL over_held_key got=%0d exp=4", bus.game_state); end
        checks++; if (bus.score !== 16'd1) begin failures++; $display("FAIL over_score got=%0d exp=1", bus.score); end
        key_start = 1'b1;
        cyc(4);
        key_start = 1'b0;
        cyc(3);
        checks++; if (bus.game_state !== 4'd2) begin failures++; $display("FAIL restart_state got=%0d exp=2", bus.game_state); end
        checks++; if (bus.lives !== 2'd2) begin failures++; $display("FAIL restart_lives got=%0d exp=2", bus.lives); end
        checks++; if (bus.score !== 16'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", bus.score); end
        checks++; if (bus.ball_time_const !== 32'd100) begin failures++; $display("FAIL restart_tc got=%0d exp=100", bus.ball_time_const); end
        key_start = 1'b1;
    endtask

    // Flag lands on the edge that would apply the 5th ramp tick of the new game.
    task automatic test_hit_ramp_coincide;
        cyc(12);
        checks++; if (bus.game_state !== 4'd0) begin failures++; $display("FAIL coin_play got=%0d exp=0", bus.game_state); end
        cyc(19);
        bus.game_over_flag = 4'b0001;
        cyc(1);
        bus.game_over_flag = 4'd0;
        checks++; if (bus.game_state !== 4'd3) begin failures++; $display("FAIL coin_state got=%0d exp=3", bus.game_state); end
        checks++; if (bus.lives !== 2'd1) begin failures++; $display("FAIL coin_lives got=%0d exp=1", bus.lives); end
        checks++; if (bus.ball_time_const !== 32'd100) begin failures++; $display("FAIL coin_tc got=%0d exp=100", bus.ball_time_const); end
    endtask

    task automatic test_async_reset;
        cyc(20);
        checks++; if (bus.game_state !== 4'd0) begin failures++; $display("FAIL pre_reset_play got=%0d exp=0", bus.game_state); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.game_state !== 4'd1) begin failures++; $display("FAIL areset_state got=%0d exp=1", bus.game_state); end
        checks++; if (bus.lives !== 2'd0) begin failures++; $display("FAIL areset_lives got=%0d exp=0", bus.lives); end
        checks++; if (bus.ball_time_const !== 32'd100) begin failures++; $display("FAIL areset_tc got=%0d exp=100", bus.ball_time_const); end
        cyc(2);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start();
        test_play_score_ramp();
        test_hit();
        test_over_restart();
        test_hit_ramp_coincide();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
